// File: rtl/prio_encoder_low_seq.sv
// Handshaked priority encoder for active-low request vectors (highest-order zero wins),
// with a drain mode. Optional round-robin fixed-mode priority under ROTATE_PRIORITY_EN.
module prio_encoder_low_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] c,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_found,
    output logic             out_last
);

    typedef enum logic [1:0] {EMPTY, HOLD, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             mode_r_q, mode_r_d;

    logic [WIDTH-1:0] rev_pend;
    logic [WIDTH-1:0] rev_mask;
    logic [WIDTH-1:0] sel_mask;
    logic [IDX_W-1:0] enc_idx;
    logic             hit;
    logic             busy;
    logic             single;
    logic             hs;
    logic             acc;

`ifdef ROTATE_PRIORITY_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] start_ptr;
    assign start_ptr = (state_q == HOLD) ? rr_ptr_q : '0;
`endif

    // Reversed view makes array position equal to the MSB-relative index.
    assign rev_pend = {<<{pending_q}};
    assign sel_mask = {<<{rev_mask}};

    always_comb begin
        enc_idx  = '0;
        rev_mask = '0;
        hit      = 1'b0;
`ifdef ROTATE_PRIORITY_EN
        for (int unsigned p = 0; p < WIDTH; p++) begin
            if (!hit && rev_pend[p] && (p >= 32'(start_ptr))) begin
                hit         = 1'b1;
                enc_idx     = IDX_W'(p);
                rev_mask[p] = 1'b1;
            end
        end
`endif
        for (int unsigned p = 0; p < WIDTH; p++) begin
            if (!hit && rev_pend[p]) begin
                hit         = 1'b1;
                enc_idx     = IDX_W'(p);
                rev_mask[p] = 1'b1;
            end
        end
    end

    assign busy      = (state_q != EMPTY);
    assign single    = ((pending_q & (pending_q - WIDTH'(1))) == '0);
    assign out_valid = busy;
    assign out_found = busy & (|pending_q);
    assign out_idx   = busy ? enc_idx : '0;
    assign out_last  = busy & (~mode_r_q | single);

    assign hs       = busy & out_ready;
    assign in_ready = (state_q == EMPTY) | (hs & out_last);
    assign acc      = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        mode_r_d  = mode_r_q;
        if (acc) begin
            pending_d = ~c;
            mode_r_d  = mode;
            state_d   = mode ? DRAIN : HOLD;
        end else if (hs) begin
            if (state_q == HOLD || out_last) begin
                state_d = EMPTY;
            end else begin
                pending_d = pending_q & ~sel_mask;
            end
        end
    end

`ifdef ROTATE_PRIORITY_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs && (state_q == HOLD) && out_found) begin
            rr_ptr_d = (out_idx == IDX_W'(WIDTH - 1)) ? '0 : out_idx + IDX_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            pending_q <= '0;
            mode_r_q  <= 1'b0;
`ifdef ROTATE_PRIORITY_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mode_r_q  <= mode_r_d;
`ifdef ROTATE_PRIORITY_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_prio_encoder_low_seq.sv
// Directed bench for prio_encoder_low_seq (WIDTH=8); expected beats come from a
// scoreboard model, including round-robin when ROTATE_PRIORITY_EN is defined.
module tb_prio_encoder_low_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] c;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_found;
    logic       out_last;

    typedef struct packed {
        logic [2:0] idx;
        logic       found;
        logic       last;
    } beat_t;

    beat_t       sb[$];
    int unsigned m_rr;
    int          errors = 0;
    int          checks = 0;

    prio_encoder_low_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .c         (c),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_found (out_found),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] cw, input logic m);
        logic [7:0]  z;
        int unsigned n;
        int unsigned k;
        int          sel;
        beat_t       b;
        z = ~cw;
        n = $countones(z);
        if (n == 0) begin
            b.idx = 3'd0; b.found = 1'b0; b.last = 1'b1;
            sb.push_back(b);
        end else if (m) begin
            k = 0;
            for (int p = 0; p < 8; p++) begin
                if (z[7-p]) begin
                    k++;
                    b.idx = 3'(p); b.found = 1'b1; b.last = (k == n);
                    sb.push_back(b);
                end
            end
        end else begin
            sel = -1;
`ifdef ROTATE_PRIORITY_EN
            for (int p = 0; p < 8; p++)
                if (sel < 0 && z[7-p] && p >= int'(m_rr)) sel = p;
`endif
            for (int p = 0; p < 8; p++)
                if (sel < 0 && z[7-p]) sel = p;
            m_rr = (sel == 7) ? 0 : sel + 1;
            b.idx = 3'(sel); b.found = 1'b1; b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    // Called just after an edge: score the beat the coming edge consumes, log any accept, advance.
    task automatic tick();
        beat_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_idx",   32'(out_idx),   32'(e.idx));
                chk("beat_found", 32'(out_found), 32'(e.found));
                chk("beat_last",  32'(out_last),  32'(e.last));
            end
        end
        if (in_valid && in_ready) push_word(c, mode);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_found", 32'(out_found), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        sb.delete();
        m_rr = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] cw, input logic m);
        c = cw;
        mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; c = 8'h00; mode = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        m_rr = 0;
        #1;
        do_reset();

        // Fixed-mode single word: one-cycle latency, then idle
        send(8'b1101_0110, 1'b0);
        chk("fix_latency_valid", 32'(out_valid), 32'd1);
        chk("fix_idx_direct",    32'(out_idx),   32'd2);
        tick();
        chk("fix_after_valid", 32'(out_valid), 32'd0);

        // No request: single not-found beat
        send(8'hFF, 1'b0);
        chk("ff_found_direct", 32'(out_found), 32'd0);
        tick();

        // Drain with stall on first beat; mode toggled mid-word must be ignored
        out_ready = 1'b0;
        send(8'b1011_1101, 1'b1);
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_idx",      32'(out_idx),   32'd1);
            chk("stall_last",     32'(out_last),  32'd0);
            chk("stall_in_ready", 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("drain2_idx",  32'(out_idx),  32'd6);
        chk("drain2_last", 32'(out_last), 32'd1);

        // Back-to-back: next word accepted on the last drain handshake
        c = 8'b0111_1111; mode = 1'b0; in_valid = 1'b1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_no_bubble", 32'(out_valid), 32'd1);
        chk("b2b_idx",       32'(out_idx),   32'd0);
        tick();
        chk("b2b_idle", 32'(out_valid), 32'd0);

        // Reset in the middle of a drain
        send(8'h0F, 1'b1);
        tick();
        chk("mid_drain_busy", 32'(out_valid), 32'd1);
        do_reset();

        // All-zero words in fixed mode (round-robin when enabled), then reset pointer
        for (int i = 0; i < 3; i++) begin
            send(8'h00, 1'b0);
            tick();
        end
        do_reset();
        send(8'h00, 1'b0);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        tick();

        // Drain of a fully-requesting word, bounded
        send(8'h00, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_encoder_low_seq.md
Name: prio_encoder_low_seq

Overview:
- Parametrised, handshaked priority encoder for active-low request vectors. The highest-order zero bit wins.
- Successor to the fixed 4-bit combinational encoder. Adds a registered valid/ready output stage and a drain mode that emits every zero bit, one per beat, highest first.
- Sits between request-producing logic (status or request lines) and a serial consumer.

Parameters:
- WIDTH, 8, number of active-low request bits in c (2..64).
- IDX_W, $clog2(WIDTH), width of out_idx. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- c  input  WIDTH  request vector; bit = 0 means requesting
- mode  input  1  0 = fixed (one result beat per word), 1 = drain (one beat per zero bit)
- in_valid  input  1  c/mode valid
- in_ready  output  1  block can accept c/mode this cycle
- out_valid  output  1  result fields valid
- out_ready  input  1  consumer accepts result
- out_idx  output  IDX_W  MSB-relative index of selected zero bit (bit WIDTH-1 -> 0, bit 0 -> WIDTH-1)
- out_found  output  1  at least one zero bit present in the pending vector
- out_last  output  1  final beat for the current input word

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state EMPTY, pending = 0, mode_r = 0, out_valid = 0, out_idx = 0, out_found = 0, out_last = 0, in_ready = 1 on the first cycle after reset.
- Accept: a word is taken when in_valid && in_ready. The block latches pending = ~c and mode_r = mode.
- Latency: word accepted in cycle N gives out_valid = 1 in cycle N+1.
- in_ready = (state == EMPTY) || (out_valid && out_ready && out_last).
  - This allows back-to-back words with no bubble.
  - It is the only combinational path from out_ready to in_ready.
- Result fields are driven only from registered state (pending vector through the encoder). There is no combinational path from c to out_*.
- out_found = |pending. out_idx = MSB-relative index of the highest set pending bit; 0 when pending == 0.
- out_last:
  - fixed mode: always 1;
  - drain mode: 1 when pending has at most one set bit.
- States:
  - EMPTY: out_valid = 0. On accept -> HOLD if mode = 0, DRAIN if mode = 1.
  - HOLD: out_valid = 1. On handshake -> EMPTY, or re-enter HOLD/DRAIN if a new word is accepted the same cycle.
  - DRAIN: out_valid = 1. On handshake, clear the selected bit in pending.
    - If out_last = 1: -> EMPTY, or load a new word as in HOLD.
    - Otherwise: stay in DRAIN.
- All-ones input (no request): exactly one beat with out_found = 0, out_idx = 0, out_last = 1, in either mode.
- Stall: while out_valid && !out_ready, out_idx, out_found, out_last and pending are held stable.
- mode is sampled only on accept. Changes to mode at other times are ignored.
- Reset mid-DRAIN or mid-HOLD: pending is discarded, state -> EMPTY, all outputs take their reset values.

Optional Feature:
- Macro: ROTATE_PRIORITY_EN.
- Defined: fixed mode uses round-robin priority.
  - Rotating pointer rr_ptr (IDX_W bits, reset 0, MSB-relative).
  - Search starts at MSB-relative position rr_ptr and wraps past WIDTH-1 back to 0.
  - On each fixed-mode handshake with out_found = 1: rr_ptr <= out_idx + 1, wrapping to 0 at WIDTH.
  - Drain mode is unaffected and still runs highest-first.
- Undefined: fixed mode is strict highest-order-zero priority; rr_ptr does not exist.

Test Plan:
- Reset: rst high 2 cycles with in_valid = 1 -> out_valid = 0, out_idx = 0, out_found = 0, out_last = 0; in_ready = 1 after release.
- Fixed, c = 8'b1101_0110, out_ready = 1 -> next cycle out_valid = 1, out_found = 1, out_idx = 2, out_last = 1; then out_valid = 0.
- Fixed, c = 8'hFF -> one beat: out_found = 0, out_idx = 0, out_last = 1.
- Drain, c = 8'b1011_1101, with out_ready low for 3 cycles on the first beat:
  - beat 1: out_idx = 1, out_last = 0, held stable while stalled, in_ready = 0;
  - beat 2: out_idx = 6, out_last = 1.
- Back-to-back: in_valid held high, second word c = 8'b0111_1111 presented during the drain last-beat handshake -> accepted that cycle; next cycle out_idx = 0, no bubble.
- Reset mid-DRAIN -> state EMPTY, out_valid = 0.
  - With ROTATE_PRIORITY_EN, fixed c = 8'h00 three times -> out_idx = 0, 1, 2.
  - Then rst -> next c = 8'h00 gives out_idx = 0.
